// File: rtl/decode_alu.sv
`default_nettype none
// ============================================================================
// Module   : decode_alu
// Purpose  : ALU-control part of the main instruction decoder. Maps the
//            data-processing cmd field, the S bit (L) and the ALUOp
//            qualifier to the ALU operation select, the flag-write enables
//            and the register-write suppress signal. The outputs are
//            registered, so results appear one clock after the request.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            in_valid   - decode request; inputs are sampled when 1
//            L          - S bit (set flags) of the instruction
//            cmd[3:0]   - data-processing opcode, instr[24:21]
//            ALUOp      - 1 = data-processing, 0 = memory/branch (ADD)
//            NoWrite    - suppress register-file write
//            ALUControl - 00 ADD, 01 SUB, 10 AND, 11 ORR
//            Flagw[1:0] - [1] write N,Z ; [0] write C,V
//            out_valid  - in_valid delayed by one clock
//            Illegal    - unsupported cmd while ALUOp=1
// Options  : DECODE_ALU_CMPTST_EN - also decode CMN (1011) and TST (1000)
// Revision : 1.0 - initial release
// ============================================================================
module decode_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       L,
  input  logic [3:0] cmd,
  input  logic       ALUOp,
  output logic       NoWrite,
  output logic [1:0] ALUControl,
  output logic [1:0] Flagw,
  output logic       out_valid,
  output logic       Illegal
);

  // Opcode encodings of the cmd field
  localparam logic [3:0] c_CMD_AND = 4'b0000;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;
`ifdef DECODE_ALU_CMPTST_EN
  localparam logic [3:0] c_CMD_TST = 4'b1000;
  localparam logic [3:0] c_CMD_CMN = 4'b1011;
`endif

  // ALU operation select encodings
  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_ORR = 2'b11;

  logic       w_nowrite;
  logic [1:0] w_alu_control;
  logic [1:0] w_flagw;
  logic       w_illegal;

  logic       r_nowrite;
  logic [1:0] r_alu_control;
  logic [1:0] r_flagw;
  logic       r_out_valid;
  logic       r_illegal;

  // Combinational decode of the current request
  always_comb begin
    w_nowrite     = 1'b0;
    w_alu_control = c_ALU_ADD;
    w_flagw       = 2'b00;
    w_illegal     = 1'b0;
    if (ALUOp) begin
      case (cmd)
        c_CMD_ADD: begin
          w_alu_control = c_ALU_ADD;
          w_flagw       = {L, L};
        end
        c_CMD_SUB: begin
          w_alu_control = c_ALU_SUB;
          w_flagw       = {L, L};
        end
        // Logical ops never touch C,V
        c_CMD_AND: begin
          w_alu_control = c_ALU_AND;
          w_flagw       = {L, 1'b0};
        end
        c_CMD_ORR: begin
          w_alu_control = c_ALU_ORR;
          w_flagw       = {L, 1'b0};
        end
        // Compares always set flags, whatever the S bit says
        c_CMD_CMP: begin
          w_alu_control = c_ALU_SUB;
          w_flagw       = 2'b11;
          w_nowrite     = 1'b1;
        end
`ifdef DECODE_ALU_CMPTST_EN
        c_CMD_CMN: begin
          w_alu_control = c_ALU_ADD;
          w_flagw       = 2'b11;
          w_nowrite     = 1'b1;
        end
        c_CMD_TST: begin
          w_alu_control = c_ALU_AND;
          w_flagw       = 2'b10;
          w_nowrite     = 1'b1;
        end
`endif
        // Unsupported opcode: neither the result nor the flags are written
        default: begin
          w_alu_control = c_ALU_ADD;
          w_flagw       = 2'b00;
          w_nowrite     = 1'b1;
          w_illegal     = 1'b1;
        end
      endcase
    end
  end

  // Output registers; decode results only update on a valid request so the
  // last result is held across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nowrite     <= 1'b0;
      r_alu_control <= 2'b00;
      r_flagw       <= 2'b00;
      r_out_valid   <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_nowrite     <= w_nowrite;
        r_alu_control <= w_alu_control;
        r_flagw       <= w_flagw;
        r_illegal     <= w_illegal;
      end
    end
  end

  assign NoWrite    = r_nowrite;
  assign ALUControl = r_alu_control;
  assign Flagw      = r_flagw;
  assign out_valid  = r_out_valid;
  assign Illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_alu
// Purpose  : Directed self-checking bench for decode_alu. Each step drives a
//            request, pushes the reference result to a scoreboard queue and
//            pops/compares it once the registered output is available.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_alu;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       L;
  logic [3:0] cmd;
  logic       ALUOp;
  logic       NoWrite;
  logic [1:0] ALUControl;
  logic [1:0] Flagw;
  logic       out_valid;
  logic       Illegal;

  // Packed as {out_valid, Illegal, NoWrite, ALUControl, Flagw}
  typedef struct packed {
    logic       ov;
    logic       il;
    logic       nw;
    logic [1:0] ac;
    logic [1:0] fw;
  } exp_t;

  exp_t q_exp[$];
  exp_t r_model;
  int   checks;
  int   failures;

  decode_alu u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .L          (L),
    .cmd        (cmd),
    .ALUOp      (ALUOp),
    .NoWrite    (NoWrite),
    .ALUControl (ALUControl),
    .Flagw      (Flagw),
    .out_valid  (out_valid),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table
  function automatic exp_t ref_decode(input logic aluop, input logic s,
                                      input logic [3:0] c);
    exp_t e;
    e = '0;
    e.ov = 1'b1;
    if (aluop) begin
      case (c)
        4'd4:  begin e.ac = 2'b00; e.fw = {s, s}; end
        4'd2:  begin e.ac = 2'b01; e.fw = {s, s}; end
        4'd0:  begin e.ac = 2'b10; e.fw = {s, 1'b0}; end
        4'd12: begin e.ac = 2'b11; e.fw = {s, 1'b0}; end
        4'd10: begin e.ac = 2'b01; e.fw = 2'b11; e.nw = 1'b1; end
`ifdef DECODE_ALU_CMPTST_EN
        4'd11: begin e.ac = 2'b00; e.fw = 2'b11; e.nw = 1'b1; end
        4'd8:  begin e.ac = 2'b10; e.fw = 2'b10; e.nw = 1'b1; end
`endif
        default: begin e.il = 1'b1; e.nw = 1'b1; end
      endcase
    end
    return e;
  endfunction

  function automatic exp_t observed();
    return {out_valid, Illegal, NoWrite, ALUControl, Flagw};
  endfunction

  task automatic compare(input string tag, input exp_t exp);
    exp_t got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got ov/il/nw/ac/fw=%b/%b/%b/%b/%b exp=%b/%b/%b/%b/%b",
             tag, got.ov, got.il, got.nw, got.ac, got.fw,
             exp.ov, exp.il, exp.nw, exp.ac, exp.fw);
    end
  endtask

  // Drive one request, record the expected result, check it after the edge
  task automatic step(input string tag, input logic v, input logic aluop,
                      input logic s, input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    ALUOp    = aluop;
    L        = s;
    cmd      = c;
    if (v) begin
      r_model = ref_decode(aluop, s, c);
    end else begin
      r_model.ov = 1'b0;
    end
    q_exp.push_back(r_model);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q_exp.pop_front();
      compare(tag, e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    r_model  = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    L        = 1'b0;
    cmd      = 4'd0;
    ALUOp    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    compare("reset_initial", '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic data-processing ops
    step("add_l0",   1'b1, 1'b1, 1'b0, 4'd4);
    step("and_l0",   1'b1, 1'b1, 1'b0, 4'd0);
    step("sub_l1",   1'b1, 1'b1, 1'b1, 4'd2);
    step("add_l1",   1'b1, 1'b1, 1'b1, 4'd4);
    step("and_l1",   1'b1, 1'b1, 1'b1, 4'd0);

    // Compare and illegal
    step("cmp_l0",   1'b1, 1'b1, 1'b0, 4'd10);
    step("mov_ill",  1'b1, 1'b1, 1'b1, 4'd13);
    step("orr_l0",   1'b1, 1'b1, 1'b0, 4'd12);
    step("cmp_l1",   1'b1, 1'b1, 1'b1, 4'd10);
    step("ill_15",   1'b1, 1'b1, 1'b0, 4'd15);

    // ALUOp=0 forces ADD regardless of cmd/L
    step("aluop0",   1'b1, 1'b0, 1'b1, 4'd2);
    step("aluop0_i", 1'b1, 1'b0, 1'b0, 4'd13);

    // Hold across idle cycles
    step("hold_set", 1'b1, 1'b1, 1'b1, 4'd12);
    step("hold_1",   1'b0, 1'b1, 1'b0, 4'd2);
    step("hold_2",   1'b0, 1'b1, 1'b1, 4'd13);
    step("hold_3",   1'b0, 1'b0, 1'b0, 4'd10);

    // Optional compare/test opcodes (illegal in the default build)
    step("cmn_l0",   1'b1, 1'b1, 1'b0, 4'd11);
    step("tst_l1",   1'b1, 1'b1, 1'b1, 4'd8);

    // Asynchronous reset mid-cycle with nonzero outputs
    step("pre_rst",  1'b1, 1'b1, 1'b1, 4'd10);
    #2;
    rst = 1'b1;
    #1;
    r_model = '0;
    compare("rst_async", '0);
    @(negedge clk);
    in_valid = 1'b1;
    ALUOp    = 1'b1;
    L        = 1'b1;
    cmd      = 4'd2;
    @(posedge clk);
    #1;
    compare("rst_held", '0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    compare("rst_released", '0);

    step("post_rst", 1'b1, 1'b1, 1'b1, 4'd2);
    step("back2back",1'b1, 1'b1, 1'b0, 4'd12);

    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q_exp.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
